// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation issuer: command encodings,
// rsp_flags / sticky_status bit positions, FSM state encoding and the
// settle-counter width helper.
package alu_pkg;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'b000,
        CMD_SUB  = 3'b001,
        CMD_XOR  = 3'b010,
        CMD_SLT  = 3'b011,
        CMD_AND  = 3'b100,
        CMD_NAND = 3'b101,
        CMD_NOR  = 3'b110,
        CMD_OR   = 3'b111
    } alu_cmd_e;

    // rsp_flags = {overflow, zero, carryout}
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_OVF   = 2;

    // sticky_status = {overflow, carryout}
    localparam int STICKY_CARRY = 0;
    localparam int STICKY_OVF   = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Counter only ever holds SETTLE_CYCLES-1 down to 0.
    function automatic int cnt_width(input int settle_cycles);
        return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
    endfunction

endpackage

// File: rtl/alu_settle_counter.sv
// Purpose: down-counter timing how long ALU inputs are held before sampling.
// Latency: done asserts SETTLE_CYCLES-1 decrements after load.
// Backpressure: none; counter holds at zero until the next load.
// Ports: clk, reset (sync, active-high), load, decrement, done.
module alu_settle_counter
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic decrement,
    output logic done
);

    localparam int W = cnt_width(SETTLE_CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= W'(SETTLE_CYCLES - 1);
        end else if (decrement && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/alu_op_issuer.sv
// Purpose: issues one operation to an external ALU, waits for it to settle, captures result+flags.
// Latency: accept in cycle 0 -> rsp_valid in cycle SETTLE_CYCLES+1; accepts spaced SETTLE_CYCLES+2.
// Backpressure: rsp_ready=0 holds the response (and blocks new requests) indefinitely.
// Ports: clk/reset; req_valid/req_ready/req_a/req_b/req_cmd in; alu_a/alu_b/alu_command to ALU;
//        alu_result/alu_carryout/alu_zero/alu_overflow from ALU; rsp_valid/rsp_ready/rsp_result/
//        rsp_flags out; sticky_clr/sticky_status (active only with ALU_ISSUER_STICKY_EN defined).
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_cmd,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_command,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_flags,
    input  logic        sticky_clr,
    output logic [1:0]  sticky_status
);

    state_e     state;
    state_e     state_nxt;
    logic       load;
    logic       decrement;
    logic       capture;
    logic       settle_done;
    alu_cmd_e   cmd_q;
    logic [2:0] flags_in;

    alu_settle_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .decrement (decrement),
        .done      (settle_done)
    );

    always_comb begin
        flags_in              = '0;
        flags_in[FLAG_CARRY]  = alu_carryout;
        flags_in[FLAG_ZERO]   = alu_zero;
        flags_in[FLAG_OVF]    = alu_overflow;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        decrement = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    decrement = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            cmd_q      <= CMD_ADD;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                alu_a <= req_a;
                alu_b <= req_b;
                cmd_q <= alu_cmd_e'(req_cmd);
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_flags  <= flags_in;
            end
        end
    end

    assign alu_command = cmd_q;

    // Gated by reset so handshakes are quiet from the first reset cycle,
    // before the state register has been cleared.
    assign req_ready = (state == ST_IDLE) && !reset;
    assign rsp_valid = (state == ST_RESP) && !reset;

`ifdef ALU_ISSUER_STICKY_EN
    // A capture coinciding with a clear wins: clear first, then OR in new flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_status <= '0;
        end else if (capture) begin
            sticky_status <= (sticky_clr ? 2'b00 : sticky_status) |
                             {flags_in[FLAG_OVF], flags_in[FLAG_CARRY]};
        end else if (sticky_clr) begin
            sticky_status <= '0;
        end
    end
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_status     = 2'b00;
`endif

endmodule
